// File: rtl/ram_arbiter.sv
// Purpose : two-requester round-robin arbiter in front of a single-port RAM
//           with a fixed read latency.
// Latency : write done 2 cycles after the request edge, read done RD_LAT+2.
// Backpressure: one access in flight; requests are sampled only in IDLE and
//               must be held until gnt, so a busy arbiter simply leaves
//               them waiting.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req0/1, we0/1               access request and write enable per requester
//   addr0/1, wdata0/1           operands per requester
//   gnt0/1                      one-cycle grant pulse (coincides with ram_en)
//   done0/1                     one-cycle completion pulse
//   rdata0/1                    last read result per requester
//   ram_en, ram_we              RAM strobe and write enable
//   ram_addr, ram_wdata         RAM operands (hold their last value)
//   ram_rdata                   RAM read data, valid RD_LAT cycles after ram_en
//   busy                        high while an access is in flight

module ram_arbiter #(
  parameter int DWIDTH = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [DWIDTH-1:0] addr0,
  input  logic [DWIDTH-1:0] addr1,
  input  logic [DWIDTH-1:0] wdata0,
  input  logic [DWIDTH-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DWIDTH-1:0] rdata0,
  output logic [DWIDTH-1:0] rdata1,
  output logic              ram_en,
  output logic              ram_we,
  output logic [DWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_wdata,
  input  logic [DWIDTH-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Counter value on the final WAIT cycle, i.e. the cycle ram_rdata is valid.
  localparam logic [2:0] LAST_CNT = 3'(RD_LAT - 1);

  state_t      state;
  logic        sel;       // requester owning the access in flight
  logic        last;      // requester granted most recently
  logic [2:0]  wait_cnt;
  logic        gnt0_q;
  logic        gnt1_q;
  logic        done0_q;
  logic        done1_q;
  logic        ram_en_q;
  logic        ram_we_q;
  logic        pick;

  // Lone requester always wins; on contention the one not granted last wins.
  always_comb begin
    pick = 1'b0;
    if (req0 && req1) begin
      pick = ~last;
    end else begin
      pick = req1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 1'b0;
      last      <= 1'b1;  // makes requester 0 win the first contention
      wait_cnt  <= 3'd0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      ram_en_q  <= 1'b0;
      ram_we_q  <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      ram_en_q <= 1'b0;
      ram_we_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            // ram_addr/ram_wdata/ram_we_q double as the operand latch, so
            // requester input changes after this edge cannot leak in.
            sel       <= pick;
            last      <= pick;
            gnt0_q    <= ~pick;
            gnt1_q    <= pick;
            ram_en_q  <= 1'b1;
            ram_we_q  <= pick ? we1 : we0;
            ram_addr  <= pick ? addr1 : addr0;
            ram_wdata <= pick ? wdata1 : wdata0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (ram_we_q) begin
            done0_q <= ~sel;
            done1_q <= sel;
            state   <= RESP;
          end else begin
            wait_cnt <= 3'd0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == LAST_CNT) begin
            if (sel) begin
              rdata1 <= ram_rdata;
            end else begin
              rdata0 <= ram_rdata;
            end
            done0_q  <= ~sel;
            done1_q  <= sel;
            wait_cnt <= 3'd0;
            state    <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Control outputs are forced low for the whole time rst is high, including
  // the first reset cycle before the reset edge has updated the registers.
  assign gnt0   = gnt0_q   & ~rst;
  assign gnt1   = gnt1_q   & ~rst;
  assign done0  = done0_q  & ~rst;
  assign done1  = done1_q  & ~rst;
  assign ram_en = ram_en_q & ~rst;
  assign ram_we = ram_we_q & ~rst;
  assign busy   = (state != IDLE) & ~rst;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1, wdata0, wdata1, ram_rdata;

  // Instance A: RD_LAT = 1
  logic        gnt0_a, gnt1_a, done0_a, done1_a, ram_en_a, ram_we_a, busy_a;
  logic [15:0] rdata0_a, rdata1_a, ram_addr_a, ram_wdata_a;
  // Instance B: RD_LAT = 4
  logic        gnt0_b, gnt1_b, done0_b, done1_b, ram_en_b, ram_we_b, busy_b;
  logic [15:0] rdata0_b, rdata1_b, ram_addr_b, ram_wdata_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.DWIDTH(16), .RD_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0_a), .gnt1(gnt1_a), .done0(done0_a), .done1(done1_a),
    .rdata0(rdata0_a), .rdata1(rdata1_a),
    .ram_en(ram_en_a), .ram_we(ram_we_a),
    .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a),
    .ram_rdata(ram_rdata), .busy(busy_a)
  );

  ram_arbiter #(.DWIDTH(16), .RD_LAT(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .done0(done0_b), .done1(done1_b),
    .rdata0(rdata0_b), .rdata1(rdata1_b),
    .ram_en(ram_en_b), .ram_we(ram_we_b),
    .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b),
    .ram_rdata(ram_rdata), .busy(busy_b)
  );

  // One row = inputs for a cycle plus outputs expected during that cycle.
  // ctl bit order: {gnt0, gnt1, done0, done1, ram_en, ram_we, busy}
  typedef struct {
    logic        rst;
    logic        req0;
    logic        we0;
    logic [15:0] addr0;
    logic [15:0] wdata0;
    logic        req1;
    logic        we1;
    logic [15:0] addr1;
    logic [15:0] wdata1;
    logic [15:0] rrd;
    logic [6:0]  ctl;
    logic [15:0] ea;
    logic [15:0] ew;
    logic [15:0] er0;
    logic [15:0] er1;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t v(input logic r,
                             input logic q0, input logic w0,
                             input logic [15:0] a0, input logic [15:0] d0,
                             input logic q1, input logic w1,
                             input logic [15:0] a1, input logic [15:0] d1,
                             input logic [15:0] rr, input logic [6:0] c,
                             input logic [15:0] ea, input logic [15:0] ew,
                             input logic [15:0] e0, input logic [15:0] e1);
    vec_t t;
    t.rst = r; t.req0 = q0; t.we0 = w0; t.addr0 = a0; t.wdata0 = d0;
    t.req1 = q1; t.we1 = w1; t.addr1 = a1; t.wdata1 = d1; t.rrd = rr;
    t.ctl = c; t.ea = ea; t.ew = ew; t.er0 = e0; t.er1 = e1;
    return t;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; ram_rdata = 0;
  endtask

  // Leaves the caller at posedge+1 of the first cycle with rst low.
  task automatic do_reset();
    rst = 1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gseq[4];
    int ng, first_c, ov, done_k, busy_cnt, n_g0, n_g1, n_d0;
    logic found, saw_gnt, rd_ok_busy;
    logic [15:0] rd_at_done;

    rst = 1;
    clear_inputs();
    repeat (2) @(posedge clk);

    // ---------------- table-driven section, instance A (RD_LAT=1) ----------
    tbl[0]  = v(1, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000, 7'b0000000, 16'h0000,16'h0000,16'h0000,16'h0000);
    tbl[1]  = v(0, 1,0,16'h0010,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000, 7'b0000000, 16'h0000,16'h0000,16'h0000,16'h0000);
    tbl[2]  = v(0, 1,0,16'h9999,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000, 7'b1000101, 16'h0010,16'h0000,16'h0000,16'h0000);
    tbl[3]  = v(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'hBEEF, 7'b0000001, 16'h0010,16'h0000,16'h0000,16'h0000);
    tbl[4]  = v(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000, 7'b0010001, 16'h0010,16'h0000,16'hBEEF,16'h0000);
    tbl[5]  = v(0, 0,0,16'h0000,16'h0000, 1,1,16'h0004,16'h1234, 16'h0000, 7'b0000000, 16'h0010,16'h0000,16'hBEEF,16'h0000);
    tbl[6]  = v(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000, 7'b0100111, 16'h0004,16'h1234,16'hBEEF,16'h0000);
    tbl[7]  = v(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000, 7'b0001001, 16'h0004,16'h1234,16'hBEEF,16'h0000);
    tbl[8]  = v(0, 1,1,16'h0020,16'h00A0, 1,0,16'h0030,16'h0000, 16'h0000, 7'b0000000, 16'h0004,16'h1234,16'hBEEF,16'h0000);
    tbl[9]  = v(0, 1,1,16'h0020,16'h00A0, 1,0,16'h0030,16'h0000, 16'h0000, 7'b1000111, 16'h0020,16'h00A0,16'hBEEF,16'h0000);
    tbl[10] = v(0, 1,1,16'h0020,16'h00A0, 1,0,16'h0030,16'h0000, 16'h0000, 7'b0010001, 16'h0020,16'h00A0,16'hBEEF,16'h0000);
    tbl[11] = v(0, 1,1,16'h0020,16'h00A0, 1,0,16'h0030,16'h0000, 16'h0000, 7'b0000000, 16'h0020,16'h00A0,16'hBEEF,16'h0000);
    tbl[12] = v(0, 1,1,16'h0020,16'h00A0, 0,0,16'h0000,16'h0000, 16'h0000, 7'b0100101, 16'h0030,16'h0000,16'hBEEF,16'h0000);
    tbl[13] = v(0, 1,1,16'h0020,16'h00A0, 0,0,16'h0000,16'h0000, 16'hCAFE, 7'b0000001, 16'h0030,16'h0000,16'hBEEF,16'h0000);
    tbl[14] = v(0, 1,1,16'h0020,16'h00A0, 0,0,16'h0000,16'h0000, 16'h0000, 7'b0001001, 16'h0030,16'h0000,16'hBEEF,16'hCAFE);
    tbl[15] = v(0, 1,1,16'h0020,16'h00A0, 0,0,16'h0000,16'h0000, 16'h0000, 7'b0000000, 16'h0030,16'h0000,16'hBEEF,16'hCAFE);
    tbl[16] = v(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000, 7'b1000111, 16'h0020,16'h00A0,16'hBEEF,16'hCAFE);
    tbl[17] = v(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000, 7'b0010001, 16'h0020,16'h00A0,16'hBEEF,16'hCAFE);
    tbl[18] = v(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000, 7'b0000000, 16'h0020,16'h00A0,16'hBEEF,16'hCAFE);

    for (int i = 0; i < 19; i++) begin
      @(posedge clk);
      #1;
      rst = tbl[i].rst;
      req0 = tbl[i].req0; we0 = tbl[i].we0; addr0 = tbl[i].addr0; wdata0 = tbl[i].wdata0;
      req1 = tbl[i].req1; we1 = tbl[i].we1; addr1 = tbl[i].addr1; wdata1 = tbl[i].wdata1;
      ram_rdata = tbl[i].rrd;
      @(negedge clk);
      chk($sformatf("row%0d {ctl,addr,wdata,rd0,rd1}", i),
          {57'd0, gnt0_a, gnt1_a, done0_a, done1_a, ram_en_a, ram_we_a, busy_a,
           ram_addr_a, ram_wdata_a, rdata0_a, rdata1_a},
          {57'd0, tbl[i].ctl, tbl[i].ea, tbl[i].ew, tbl[i].er0, tbl[i].er1});
    end

    // ---------------- contention from reset, instance A ---------------------
    @(posedge clk);
    do_reset();
    req0 = 1; we0 = 1; addr0 = 16'h0100; wdata0 = 16'h0A0A;
    req1 = 1; we1 = 1; addr1 = 16'h0200; wdata1 = 16'h0B0B;
    ng = 0; first_c = -1; ov = 0;
    for (int k = 0; k < 4; k++) gseq[k] = -1;
    for (int c = 0; c < 30 && ng < 4; c++) begin
      @(negedge clk);
      if ((gnt0_a | gnt1_a) & (done0_a | done1_a)) ov++;
      if (gnt0_a | gnt1_a) begin
        if (ng == 0) first_c = c;
        gseq[ng] = gnt1_a ? 1 : 0;
        ng++;
      end
    end
    @(posedge clk);
    #1 req0 = 0; req1 = 0;
    repeat (4) @(posedge clk);
    chk("contention grant count", 128'(ng), 128'd4);
    chk("contention first grant cycle", 128'(first_c), 128'd1);
    chk("contention grant 1 owner", 128'(gseq[0]), 128'd0);
    chk("contention grant 2 owner", 128'(gseq[1]), 128'd1);
    chk("contention grant 3 owner", 128'(gseq[2]), 128'd0);
    chk("contention grant 4 owner", 128'(gseq[3]), 128'd1);
    chk("contention gnt/done overlap", 128'(ov), 128'd0);

    // ---------------- withdrawn request, instance A -------------------------
    @(posedge clk);
    do_reset();
    req0 = 1; we0 = 0; addr0 = 16'h0050;
    n_g0 = 0; n_g1 = 0; n_d0 = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_g0 += int'(gnt0_a);
      n_g1 += int'(gnt1_a);
      n_d0 += int'(done0_a);
      @(posedge clk);
      #1;
      if (c == 0) req0 = 0;
      if (c == 1) begin req1 = 1; we1 = 0; addr1 = 16'h0060; end
      if (c == 2) req1 = 0;
    end
    chk("withdrawn gnt1 count", 128'(n_g1), 128'd0);
    chk("withdrawn gnt0 count", 128'(n_g0), 128'd1);
    chk("withdrawn done0 count", 128'(n_d0), 128'd1);

    // ---------------- read latency, instance B (RD_LAT=4) -------------------
    do_reset();
    req0 = 1; we0 = 0; addr0 = 16'h0040; ram_rdata = 16'h4444;
    found = 0; done_k = -1; busy_cnt = 0; rd_at_done = 0; rd_ok_busy = 0;
    for (int k = 0; k < 16 && !found; k++) begin
      @(negedge clk);
      saw_gnt = gnt0_b;
      if (done0_b) begin
        found = 1; done_k = k; rd_at_done = rdata0_b; rd_ok_busy = busy_b;
      end else if (busy_b) begin
        busy_cnt++;
      end
      @(posedge clk);
      #1;
      if (saw_gnt) req0 = 0;
    end
    chk("latency done0 cycle", 128'(done_k), 128'd6);
    chk("latency busy cycles before done", 128'(busy_cnt), 128'd5);
    chk("latency busy in done cycle", 128'(rd_ok_busy), 128'd1);
    chk("latency rdata0 at done", 128'(rd_at_done), 128'h4444);
    @(negedge clk);
    chk("latency busy after resp", 128'(busy_b), 128'd0);

    // ---------------- reset in WAIT, instance B -----------------------------
    @(posedge clk);
    #1;
    req0 = 1; we0 = 0; addr0 = 16'h0070; ram_rdata = 16'h7777;  // cycle 0
    repeat (3) @(posedge clk);
    #1 rst = 1;                                                 // cycle 3: WAIT
    @(negedge clk);
    chk("rst-high outputs {busy,done0,gnt0,ram_en}",
        128'({busy_b, done0_b, gnt0_b, ram_en_b}), 128'd0);
    @(posedge clk);
    #1 rst = 0;                                                 // cycle 4
    @(negedge clk);
    chk("after abort {busy,done0,gnt0}", 128'({busy_b, done0_b, gnt0_b}), 128'd0);
    chk("after abort rdata0", 128'(rdata0_b), 128'd0);
    @(posedge clk);
    #1;                                                         // cycle 5
    @(negedge clk);
    chk("after abort new gnt0", 128'(gnt0_b), 128'd1);
    chk("after abort new ram_addr", 128'(ram_addr_b), 128'h0070);
    @(posedge clk);
    #1 req0 = 0;
    repeat (10) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, meaning data and address width.
REQ-002 SHALL have parameter RD_LAT, default 1, legal range 1..7, meaning RAM read latency in cycles from the ram_en cycle to the ram_rdata valid cycle.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, the reset: synchronous, active-high.
REQ-005 SHALL have ports req0/req1, input, 1 bit each, the access requests from requester 0 (CPU fetch) and requester 1 (program loader).
REQ-006 SHALL have ports we0/we1, input, 1 bit each, write enables (1 = write, 0 = read).
REQ-007 SHALL have ports addr0/addr1 and wdata0/wdata1, input, DWIDTH bits each.
REQ-008 SHALL have ports gnt0/gnt1, output, 1 bit each, one-cycle grant pulses.
REQ-009 SHALL have ports done0/done1, output, 1 bit each, one-cycle completion pulses.
REQ-010 SHALL have ports rdata0/rdata1, output, DWIDTH bits each, read result per requester.
REQ-011 SHALL have ports ram_en and ram_we, output, 1 bit each, the RAM strobe and write enable.
REQ-012 SHALL have ports ram_addr and ram_wdata, output, DWIDTH bits each.
REQ-013 SHALL have port ram_rdata, input, DWIDTH bits.
REQ-014 SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-015 SHALL implement four states:
- IDLE
- ISSUE
- WAIT
- RESP
REQ-016 In IDLE with any req high at a clock edge, the block SHALL do all of the following on that edge:
- select one requester;
- latch that requester's we, addr and wdata;
- enter ISSUE.
REQ-017 In IDLE with no req high, the block SHALL remain in IDLE.
REQ-018 Arbitration SHALL be round-robin:
- a single requester is always selected;
- when both requests are high, the requester not granted last SHALL be selected;
- the last-granted pointer updates only on selection.
REQ-019 In ISSUE, for exactly one cycle, the block SHALL:
- assert gnt of the selected requester;
- assert ram_en;
- drive ram_we, ram_addr and ram_wdata from the latched values.
REQ-020 Outside ISSUE, ram_en, ram_we and both gnt outputs SHALL be 0.
REQ-021 ram_addr and ram_wdata SHALL hold their last values outside ISSUE.
REQ-022 A write SHALL go from ISSUE to RESP; done is therefore asserted 2 cycles after the requesting IDLE edge cycle.
REQ-023 A read SHALL go from ISSUE to WAIT, then stay in WAIT for exactly RD_LAT cycles, counted by a 3-bit counter.
REQ-024 On the last WAIT cycle the block SHALL capture ram_rdata into the rdata register of the selected requester, then enter RESP.
REQ-025 Read timing: req seen at cycle T, ISSUE at T+1, done at T+2+RD_LAT.
REQ-026 In RESP, done of the selected requester SHALL be 1 for one cycle, then the block SHALL return to IDLE.
REQ-027 rdataN SHALL be valid in the done cycle and SHALL hold until requester N's next read completes.
REQ-028 Writes SHALL NOT modify rdata0 or rdata1.
REQ-029 Requests SHALL be sampled only in IDLE:
- requests arriving while busy wait;
- a request withdrawn before selection is never served.
REQ-030 A requester SHALL hold req and its operands until it sees gnt; after gnt, changes to that requester's inputs SHALL NOT affect the transaction in flight.
REQ-031 A req still high in the cycle after RESP SHALL be treated as a new transaction.
REQ-032 Back-to-back throughput SHALL be one read per RD_LAT+3 cycles and one write per 3 cycles.
REQ-033 Each done pulse SHALL be preceded by exactly one gnt pulse to the same requester.

Reset
REQ-034 With rst high at a clock edge, on that edge the block SHALL:
- enter IDLE;
- clear the WAIT counter;
- clear rdata0, rdata1, ram_addr and ram_wdata to 0;
- set the round-robin pointer so requester 0 wins the first contention.
REQ-035 While rst is high, all outputs other than the data registers SHALL be 0, covering gnt0/1, done0/1, ram_en, ram_we and busy.
REQ-036 Reset asserted in any state other than IDLE SHALL abort the transaction:
- no done is issued for it;
- the captured read data is discarded;
- a write already issued in ISSUE stands.
REQ-037 The first request can be sampled on the first edge with rst low.

Verification
REQ-038 Read, RD_LAT=1: req0=1, we0=0, addr0=0x0010 at T; ram_rdata=0xBEEF at T+2 -> gnt0 and ram_en=1 with ram_addr=0x0010 at T+1, done0=1 with rdata0=0xBEEF at T+3.
REQ-039 Write: req1=1, we1=1, addr1=0x0004, wdata1=0x1234 -> ram_en=ram_we=1, ram_addr=0x0004, ram_wdata=0x1234 at T+1; done1 at T+2; rdata1 unchanged.
REQ-040 Contention from reset: req0=req1=1 held -> grants ordered gnt0, gnt1, gnt0, gnt1; no done pulses on the same cycle as any gnt.
REQ-041 Latency, RD_LAT=4: single read -> done0 exactly 6 cycles after the request edge; busy=1 for 5 cycles.
REQ-042 Reset mid-read: rst=1 in a WAIT cycle -> next cycle busy=0, no done0, rdata0=0; req0 held -> new gnt0 on the second cycle after rst drops.
REQ-043 Withdrawn request: req1 pulsed for one cycle while busy serving req0 -> no gnt1 is ever issued.
